// File: rtl/blvds_pkg.sv
// Shared definitions for the BLVDS frame receiver: word layout, header fields,
// FSM states and sticky error bit positions.
package blvds_pkg;

    localparam int unsigned WORD_W    = 18;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned SOF_BIT   = 17;
    localparam int unsigned VALID_BIT = 16;

    localparam int unsigned ERR_W   = 3;
    localparam int unsigned ERR_LEN = 0;
    localparam int unsigned ERR_TMO = 1;
    localparam int unsigned ERR_OVF = 2;

    // Header payload: data[15:8] = frame type, data[7:0] = payload length
    typedef struct packed {
        logic [7:0] ftype;
        logic [7:0] len;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE,
        ST_DROP
    } state_e;

endpackage

// File: rtl/blvds_bank_ctrl.sv
// Ping-pong bank bookkeeping: busy flags per bank and the current write bank.
// A completed frame marks its bank busy and flips to the other bank.
module blvds_bank_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       done,
    input  logic       free,
    input  logic       free_bank,
    output logic       wr_bank,
    output logic [1:0] busy
);

    // Completion on the write bank outranks a release of that same bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            busy    <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (done && (1'(b) == wr_bank)) begin
                    busy[b] <= 1'b1;
                end else if (free && (1'(b) == free_bank)) begin
                    busy[b] <= 1'b0;
                end
            end
            if (done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

endmodule

// File: rtl/blvds_frame_rx.sv
// BLVDS frame receiver: delineates SOF/VALID framed words, checks length and
// idle gaps, writes payload into a ping-pong buffer and announces finished frames.
module blvds_frame_rx import blvds_pkg::*; #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 255,
    parameter int unsigned GAP_MAX   = 64
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [WORD_W-1:0] iDATA_BLVDS,
    input  logic              iBANK_FREE,
    input  logic              iFREE_BANK,
    input  logic              iERR_CLR,
    output logic              oWR_EN,
    output logic [ADDR_W:0]   oWR_ADDR,
    output logic [DATA_W-1:0] oWR_DATA,
    output logic              oFRAME_RDY,
    output logic              oFRAME_BANK,
    output logic [7:0]        oFRAME_LEN,
    output logic [7:0]        oFRAME_TYPE,
    output logic              oBUSY,
    output logic [ERR_W-1:0]  oERR_STAT
);

    localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

    state_e            state;
    logic [WORD_W-1:0] d_q;
    logic [ADDR_W-1:0] cnt;
    logic [GAP_W-1:0]  gap;
    hdr_t              hdr_q;
    logic              wr_bank;
    logic [1:0]        busy;

    hdr_t              hdr_c;
    logic              valid_c;
    logic              sof_c;
    logic              done_c;
    logic              len_bad_c;
    logic              start_c;
    logic              ovf_c;
    logic              last_c;
    logic              tmo_c;
    logic [ERR_W-1:0]  err_set_c;

    assign valid_c = d_q[VALID_BIT];
    assign sof_c   = d_q[SOF_BIT] & valid_c;
    assign hdr_c   = hdr_t'(d_q[DATA_W-1:0]);
    assign done_c  = (state == ST_DONE);

    // Header evaluation and error events; a SOF inside a frame aborts it and is
    // judged as a fresh header in the same cycle
    always_comb begin
        err_set_c = '0;
        start_c   = 1'b0;
        ovf_c     = 1'b0;
        len_bad_c = (hdr_c.len == 8'd0) || (32'(hdr_c.len) > MAX_WORDS);
        last_c    = ((32'(cnt) + 32'd1) == 32'(hdr_q.len));
        tmo_c     = (state == ST_RECV) && !valid_c && (gap == GAP_W'(GAP_MAX - 1));
        if (sof_c && (state != ST_DONE)) begin
            if (state == ST_RECV) begin
                err_set_c[ERR_LEN] = 1'b1;
            end
            if (len_bad_c) begin
                err_set_c[ERR_LEN] = 1'b1;
            end else if (busy[wr_bank]) begin
                err_set_c[ERR_OVF] = 1'b1;
                ovf_c              = 1'b1;
            end else begin
                start_c = 1'b1;
            end
        end
        if (tmo_c) begin
            err_set_c[ERR_TMO] = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            d_q         <= '0;
            state       <= ST_IDLE;
            cnt         <= '0;
            gap         <= '0;
            hdr_q       <= '0;
            oWR_EN      <= 1'b0;
            oWR_ADDR    <= '0;
            oWR_DATA    <= '0;
            oFRAME_RDY  <= 1'b0;
            oFRAME_BANK <= 1'b0;
            oFRAME_LEN  <= '0;
            oFRAME_TYPE <= '0;
            oBUSY       <= 1'b0;
            oERR_STAT   <= '0;
        end else begin
            d_q        <= iDATA_BLVDS;
            oWR_EN     <= 1'b0;
            oFRAME_RDY <= 1'b0;
            oERR_STAT  <= (oERR_STAT & ~{ERR_W{iERR_CLR}}) | err_set_c;

            if (start_c) begin
                state <= ST_RECV;
                oBUSY <= 1'b1;
                hdr_q <= hdr_c;
                cnt   <= '0;
                gap   <= '0;
            end else if (ovf_c) begin
                state <= ST_DROP;
                oBUSY <= 1'b1;
            end else if (sof_c && (state != ST_DONE)) begin
                state <= ST_IDLE;
                oBUSY <= 1'b0;
            end else begin
                case (state)
                    ST_RECV: begin
                        if (valid_c) begin
                            oWR_EN   <= 1'b1;
                            oWR_ADDR <= {wr_bank, cnt};
                            oWR_DATA <= d_q[DATA_W-1:0];
                            cnt      <= cnt + ADDR_W'(1);
                            gap      <= '0;
                            if (last_c) begin
                                state <= ST_DONE;
                            end
                        end else if (tmo_c) begin
                            state <= ST_IDLE;
                            oBUSY <= 1'b0;
                        end else if (gap != GAP_W'(GAP_MAX)) begin
                            gap <= gap + GAP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        oFRAME_RDY  <= 1'b1;
                        oFRAME_BANK <= wr_bank;
                        oFRAME_LEN  <= hdr_q.len;
                        oFRAME_TYPE <= hdr_q.ftype;
                        state       <= ST_IDLE;
                        oBUSY       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    blvds_bank_ctrl u_bank (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .done      (done_c),
        .free      (iBANK_FREE),
        .free_bank (iFREE_BANK),
        .wr_bank   (wr_bank),
        .busy      (busy)
    );

endmodule

// File: tb/tb_blvds_frame_rx.sv
// Scoreboard bench for blvds_frame_rx: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_blvds_frame_rx;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 12;
    localparam int unsigned GAP_MAX   = 16;

    logic              iCLK        = 1'b0;
    logic              iRST_N      = 1'b0;
    logic [17:0]       iDATA_BLVDS = '0;
    logic              iBANK_FREE  = 1'b0;
    logic              iFREE_BANK  = 1'b0;
    logic              iERR_CLR    = 1'b0;
    logic              oWR_EN;
    logic [ADDR_W:0]   oWR_ADDR;
    logic [15:0]       oWR_DATA;
    logic              oFRAME_RDY;
    logic              oFRAME_BANK;
    logic [7:0]        oFRAME_LEN;
    logic [7:0]        oFRAME_TYPE;
    logic              oBUSY;
    logic [2:0]        oERR_STAT;

    blvds_frame_rx #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .GAP_MAX(GAP_MAX)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iDATA_BLVDS (iDATA_BLVDS),
        .iBANK_FREE  (iBANK_FREE),
        .iFREE_BANK  (iFREE_BANK),
        .iERR_CLR    (iERR_CLR),
        .oWR_EN      (oWR_EN),
        .oWR_ADDR    (oWR_ADDR),
        .oWR_DATA    (oWR_DATA),
        .oFRAME_RDY  (oFRAME_RDY),
        .oFRAME_BANK (oFRAME_BANK),
        .oFRAME_LEN  (oFRAME_LEN),
        .oFRAME_TYPE (oFRAME_TYPE),
        .oBUSY       (oBUSY),
        .oERR_STAT   (oERR_STAT)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct { int cyc; logic [ADDR_W:0] addr; logic [15:0] data; } wr_exp_t;
    typedef struct { int cyc; logic bank; logic [7:0] len; logic [7:0] ftype; } fr_exp_t;

    wr_exp_t wr_q[$];
    fr_exp_t fr_q[$];
    wr_exp_t w_m;
    fr_exp_t f_m;
    int tests = 0;
    int fails = 0;

    // Reference model: state kept per frame, not per cycle
    logic       m_bank = 1'b0;
    logic [1:0] m_busy = 2'b00;
    logic [2:0] m_err  = 3'b000;
    bit         m_drop = 1'b0;
    bit         m_open = 1'b0;
    int         intra  = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write / frame announcement must match the head of its queue
    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (oWR_EN) begin
                if (wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h at cycle %0d, expected none",
                             oWR_ADDR, oWR_DATA, cyc);
                end else begin
                    w_m = wr_q.pop_front();
                    check("write", {32'(cyc), 7'd0, oWR_ADDR, oWR_DATA},
                          {32'(w_m.cyc), 7'd0, w_m.addr, w_m.data});
                end
            end
            if (oFRAME_RDY) begin
                if (fr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got bank %0d len %0d type 0x%0h at cycle %0d, expected none",
                             oFRAME_BANK, oFRAME_LEN, oFRAME_TYPE, cyc);
                end else begin
                    f_m = fr_q.pop_front();
                    check("frame", {32'(cyc), 15'd0, oFRAME_BANK, oFRAME_LEN, oFRAME_TYPE},
                          {32'(f_m.cyc), 15'd0, f_m.bank, f_m.len, f_m.ftype});
                end
            end
        end
    end

    task automatic step(input logic sof, input logic valid, input logic [15:0] d,
                        input logic fr, input logic fb, input logic clr, output int c);
        @(posedge iCLK);
        #1;
        iDATA_BLVDS = {sof, valid, d};
        iBANK_FREE  = fr;
        iFREE_BANK  = fb;
        iERR_CLR    = clr;
        c = cyc;
    endtask

    task automatic idle(input int k);
        int c;
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0, c);
    endtask

    // Header N, then `cut` payload words; cut<N ends in timeout (tmo) or an
    // interruption by the next header (caller sends it with lead 0)
    task automatic send_frame(input int n, input logic [7:0] ty, input int lead, input int cut,
                              input bit tmo, input bit stall, input logic [15:0] pat);
        int c;
        bit acc;
        logic [15:0] d;
        idle(lead);
        if (m_open) m_err[0] = 1'b1;
        m_open = 1'b0;
        acc = 1'b0;
        if (n == 0 || n > int'(MAX_WORDS)) begin
            m_err[0] = 1'b1;
            m_drop = 1'b0;
        end else if (m_busy[m_bank]) begin
            m_err[2] = 1'b1;
            m_drop = 1'b1;
        end else begin
            acc = 1'b1;
            m_drop = 1'b0;
        end
        step(1'b1, 1'b1, {ty, 8'(n)}, 1'b0, 1'b0, 1'b0, c);
        for (int i = 0; i < cut; i++) begin
            idle((stall && i == 1) ? int'(GAP_MAX - 1) : int'($urandom_range(0, intra)));
            d = (pat != 16'h0) ? 16'(pat * (i + 1)) : 16'($urandom);
            step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, c);
            if (acc) wr_q.push_back('{c + 2, {m_bank, ADDR_W'(i)}, d});
        end
        if (acc) begin
            if (cut == n) begin
                fr_q.push_back('{c + 3, m_bank, 8'(n), ty});
                m_busy[m_bank] = 1'b1;
                m_bank = ~m_bank;
            end else if (tmo) begin
                idle(int'(GAP_MAX));
                m_err[1] = 1'b1;
            end else begin
                m_open = 1'b1;
            end
        end
    endtask

    task automatic free_bank(input logic b);
        int c;
        idle(3);
        step(1'b0, 1'b0, 16'h0, 1'b1, b, 1'b0, c);
        m_busy[b] = 1'b0;
    endtask

    task automatic clear_err();
        int c;
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, c);
        m_err = 3'b000;
    endtask

    task automatic check_status(input string name);
        idle(3);
        check(name, 64'({oBUSY, oERR_STAT}), 64'({m_drop, m_err}));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({oWR_EN, oWR_ADDR, oWR_DATA, oFRAME_RDY, oFRAME_BANK,
                         oFRAME_LEN, oFRAME_TYPE, oBUSY, oERR_STAT}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int r;
        repeat (3) @(posedge iCLK);
        #1;
        check_reset_outputs("reset_state");
        @(negedge iCLK) iRST_N = 1'b1;

        intra = 0;
        send_frame(4, 8'h33, 2, 4, 1'b0, 1'b0, 16'h1111);
        check_status("basic_frame");

        send_frame(3, 8'h44, 3, 3, 1'b0, 1'b0, 16'h0);
        check_status("second_bank");
        send_frame(2, 8'h55, 3, 2, 1'b0, 1'b0, 16'h0);
        check_status("overflow_drop");
        free_bank(1'b0);
        send_frame(2, 8'h66, 3, 2, 1'b0, 1'b0, 16'h0);
        check_status("after_free");
        clear_err();
        check_status("clear_ovf");

        intra = 2;
        free_bank(1'b1);
        send_frame(3, 8'h77, 3, 2, 1'b1, 1'b0, 16'h0);
        check_status("gap_timeout");
        send_frame(1, 8'h78, 3, 1, 1'b0, 1'b0, 16'h0);
        check_status("same_bank_after_tmo");

        free_bank(1'b0);
        free_bank(1'b1);
        send_frame(5, 8'h88, 3, 2, 1'b0, 1'b0, 16'h0);
        send_frame(2, 8'h99, 0, 2, 1'b0, 1'b0, 16'h0);
        check_status("sof_abort");

        clear_err();
        send_frame(0, 8'h01, 3, 0, 1'b0, 1'b0, 16'h0);
        check_status("len_zero");
        clear_err();
        check_status("len_clear");
        send_frame(int'(MAX_WORDS) + 1, 8'h02, 3, 2, 1'b0, 1'b0, 16'h0);
        check_status("len_over_max");

        // Clear in the very cycle the length error is flagged: the error survives
        free_bank(1'b0);
        free_bank(1'b1);
        send_frame(2, 8'h03, 3, 1, 1'b1, 1'b0, 16'h0);
        send_frame(0, 8'h04, 3, 0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, c);
        m_err = 3'b001;
        check_status("clear_vs_set");

        send_frame(3, 8'h05, 3, 3, 1'b0, 1'b1, 16'h0);
        check_status("gap_just_below_max");

        free_bank(1'b0);
        free_bank(1'b1);
        send_frame(6, 8'h5A, 3, 2, 1'b0, 1'b0, 16'h0);
        @(posedge iCLK);
        #1 iRST_N = 1'b0;
        #1 check_reset_outputs("async_reset_mid_frame");
        wr_q.delete();
        fr_q.delete();
        m_bank = 1'b0;
        m_busy = 2'b00;
        m_err  = 3'b000;
        m_drop = 1'b0;
        m_open = 1'b0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK) iRST_N = 1'b1;
        send_frame(1, 8'hC3, 2, 1, 1'b0, 1'b0, 16'h0);
        check_status("frame_after_reset");

        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                n = int'($urandom_range(1, MAX_WORDS));
                send_frame(n, 8'($urandom), 3, n, 1'b0, 1'b0, 16'h0);
            end else if (r == 5) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_WORDS + 1, 255));
                send_frame(n, 8'($urandom), 3, int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0);
            end else if (r == 6) begin
                n = int'($urandom_range(2, MAX_WORDS));
                send_frame(n, 8'($urandom), 3, int'($urandom_range(0, n - 1)), 1'b1, 1'b0, 16'h0);
            end else if (r == 7) begin
                n = int'($urandom_range(2, MAX_WORDS));
                send_frame(n, 8'($urandom), 3, int'($urandom_range(0, n - 1)), 1'b0, 1'b0, 16'h0);
                n = int'($urandom_range(1, MAX_WORDS));
                send_frame(n, 8'($urandom), 0, n, 1'b0, 1'b0, 16'h0);
            end else if (r == 8) begin
                free_bank(1'($urandom));
            end else begin
                clear_err();
            end
            check_status("random_status");
        end

        idle(6);
        check("write_queue_drained", 64'(wr_q.size()), 64'd0);
        check("frame_queue_drained", 64'(fr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
